// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the 32-bit AES streaming front-end.
// The FSM state enum and the block geometry live here.
package aes_stream_pkg;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_LD   = 2'd1,
        C_RUN  = 2'd2
    } cstate_t;

    localparam int WORDS        = 4;
    localparam int CORE_LATENCY = 11;
    localparam int CNT_W        = 3;

endpackage

// File: rtl/aes_word_unpack.sv
// Holds one captured ciphertext block and drains it as 32-bit words, most
// significant word first, over a valid/ready stream.
module aes_word_unpack
    import aes_stream_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic [127:0] cap_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         empty_nxt
);

    logic [127:0]     out_buf;
    logic [CNT_W-1:0] out_cnt;
    logic             out_fire;

    assign out_fire  = out_valid && out_ready;
    assign out_valid = (out_cnt != '0);
    assign out_data  = out_buf[127:96];

    // Lets the launcher start the next block in the same cycle the last word leaves.
    assign empty_nxt = capture  ? 1'b0 :
                       out_fire ? (out_cnt == CNT_W'(1)) :
                                  (out_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_buf <= '0;
            out_cnt <= '0;
        end else if (capture) begin
            out_buf <= cap_data;
            out_cnt <= CNT_W'(WORDS);
        end else if (out_fire) begin
            out_buf <= {out_buf[95:0], 32'h0};
            out_cnt <= out_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/aes_cipher_stream.sv
// Streaming front-end for an iterative AES-128 core: packs four input words,
// launches the core, captures its ciphertext and hands it to the word unpacker.
// Streams use valid/ready: a word moves on a clock edge where both are high;
// the sender holds data stable while valid is high and ready is low.
module aes_cipher_stream
    import aes_stream_pkg::*;
#(
    parameter int DONE_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_ld,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         aes_ld,
    output logic [127:0] aes_key,
    output logic [127:0] aes_text_in,
    input  logic         aes_done,
    input  logic [127:0] aes_text_out,
    output logic         busy,
    output logic         err
);

    localparam int WDOG_W = $clog2(DONE_TIMEOUT) + 1;

    cstate_t           state, state_nxt;
    logic [CNT_W-1:0]  in_cnt, in_cnt_nxt;
    logic [127:0]      in_buf;
    logic [127:0]      key_r;
    logic [WDOG_W-1:0] wdog, wdog_nxt;
    logic              err_r, err_nxt;
    logic              capture;
    logic              in_fire;
    logic              out_empty_nxt;

    assign in_ready    = (in_cnt != CNT_W'(WORDS));
    assign in_fire     = in_valid && in_ready;
    assign aes_ld      = (state == C_LD);
    assign aes_key     = key_r;
    assign aes_text_in = in_buf;
    assign busy        = (state != C_IDLE);
    assign err         = err_r;

    // The core samples in_buf during C_LD, so the packer empties at the end of it.
    always_comb begin
        in_cnt_nxt = in_cnt;
        if (state == C_LD)
            in_cnt_nxt = '0;
        else if (in_fire)
            in_cnt_nxt = in_cnt + CNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        wdog_nxt  = wdog;
        err_nxt   = err_r;
        capture   = 1'b0;
        case (state)
            C_IDLE: begin
                // Look ahead one edge so aes_ld follows the fourth word directly.
                if (in_cnt_nxt == CNT_W'(WORDS) && out_empty_nxt)
                    state_nxt = C_LD;
            end
            C_LD: begin
                wdog_nxt  = '0;
                state_nxt = C_RUN;
            end
            C_RUN: begin
                if (aes_done) begin
                    capture   = 1'b1;
                    state_nxt = C_IDLE;
                end else if (wdog == WDOG_W'(DONE_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = C_IDLE;
                end else begin
                    wdog_nxt = wdog + WDOG_W'(1);
                end
            end
            default: state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= C_IDLE;
            in_cnt <= '0;
            in_buf <= '0;
            key_r  <= '0;
            wdog   <= '0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            in_cnt <= in_cnt_nxt;
            wdog   <= wdog_nxt;
            err_r  <= err_nxt;
            if (key_ld)
                key_r <= key_in;
            if (in_fire)
                in_buf <= {in_buf[95:0], in_data};
        end
    end

    aes_word_unpack u_unpack (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .cap_data  (aes_text_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .empty_nxt (out_empty_nxt)
    );

endmodule

// File: tb/tb_aes_cipher_stream.sv
// Bench for aes_cipher_stream with a fixed-latency stub core standing in for AES.
module tb_aes_cipher_stream;
    import aes_stream_pkg::*;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_ld;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         aes_ld;
    logic [127:0] aes_key;
    logic [127:0] aes_text_in;
    logic         aes_done;
    logic [127:0] aes_text_out;
    logic         busy;
    logic         err;

    aes_cipher_stream #(.DONE_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_ld       (key_ld),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out),
        .busy         (busy),
        .err          (err)
    );

    // ---------------- clock / reset / cycle counter ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- stub core ----------------
    function automatic logic [127:0] stub_cipher(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT)
            return FIPS_CT;
        return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    logic [3:0]   core_cnt;
    logic [127:0] core_key;
    logic [127:0] core_pt;
    logic         stub_hang;

    always @(posedge clk) begin
        if (!rst) begin
            core_cnt <= '0;
            core_key <= '0;
            core_pt  <= '0;
        end else if (aes_ld) begin
            core_cnt <= 4'd1;
            core_key <= aes_key;
            core_pt  <= aes_text_in;
        end else if (core_cnt != 0) begin
            core_cnt <= (core_cnt == 4'(CORE_LATENCY)) ? 4'd0 : core_cnt + 4'd1;
        end
    end

    assign aes_done     = (core_cnt == 4'(CORE_LATENCY)) && !stub_hang;
    assign aes_text_out = aes_done ? stub_cipher(core_key, core_pt) : 128'hdead_beef_dead_beef_dead_beef_dead_beef;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    task automatic push_block(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] ct;
        ct = stub_cipher(k, p);
        for (int i = 0; i < 4; i++)
            exp_q.push_back(ct[127 - 32*i -: 32]);
    endtask

    int   ld_cnt = 0;
    int   ld_cyc[64];
    int   ov_cnt = 0;
    int   ov_cyc[64];
    logic ov_prev = 1'b0;

    always begin
        logic [31:0] w;
        @(negedge clk);
        #2;
        if (aes_ld && ld_cnt < 64) begin
            ld_cyc[ld_cnt] = cyc;
            ld_cnt++;
        end
        if (out_valid && !ov_prev && ov_cnt < 64) begin
            ov_cyc[ov_cnt] = cyc;
            ov_cnt++;
        end
        ov_prev = out_valid;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexp_out", 128'(out_valid), 128'(0));
            end else begin
                w = exp_q.pop_front();
                check("out_word", 128'(out_data), 128'(w));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 2000 && cyc < t; i++)
            tick();
    endtask

    task automatic send_word(input logic [31:0] d, output int acc);
        in_valid = 1'b1;
        in_data  = d;
        acc      = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            if (in_ready)
                acc = cyc;
            tick();
        end
        in_valid = 1'b0;
        if (acc < 0)
            check("in_timeout", 128'(in_ready), 128'(1));
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] p,
                              input bit do_push, output int acc_last);
        int acc;
        if (do_push)
            push_block(k, p);
        for (int i = 0; i < 4; i++)
            send_word(p[127 - 32*i -: 32], acc);
        acc_last = acc;
    endtask

    task automatic wait_ld(input int n, output int l_cyc);
        for (int i = 0; i < 100 && ld_cnt < n; i++)
            tick();
        if (ld_cnt >= n) begin
            l_cyc = ld_cyc[n-1];
        end else begin
            check("ld_timeout", 128'(ld_cnt), 128'(n));
            l_cyc = -1000;
        end
    endtask

    task automatic drain(input bit rand_ready);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            if (rand_ready)
                out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  128'(in_ready),  128'(1));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_out_data"},  128'(out_data),  128'(0));
        check({tag, "_aes_ld"},    128'(aes_ld),    128'(0));
        check({tag, "_aes_key"},   aes_key,         128'(0));
        check({tag, "_text_in"},   aes_text_in,     128'(0));
        check({tag, "_busy"},      128'(busy),      128'(0));
        check({tag, "_err"},       128'(err),       128'(0));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int acc_a, acc_b, l_a, l_b, n_ld, ld_snap, ov_snap;
        logic [127:0] p;

        rst       = 1'b0;
        key_in    = '0;
        key_ld    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        stub_hang = 1'b0;
        n_ld      = 0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b1;
        tick();

        // FIPS-197 vector
        key_in = FIPS_KEY;
        key_ld = 1'b1;
        tick();
        key_ld = 1'b0;
        check("key_load", aes_key, FIPS_KEY);
        send_block(FIPS_KEY, FIPS_PT, 1'b1, acc_a);
        n_ld++;
        wait_ld(n_ld, l_a);
        check("ld_latency", 128'(l_a), 128'(acc_a + 1));
        drain(1'b0);
        check("ov_first", 128'(ov_cyc[ov_cnt-1]), 128'(l_a + CORE_LATENCY + 1));

        // back-to-back blocks
        p = rand128();
        send_block(FIPS_KEY, FIPS_PT, 1'b1, acc_a);
        send_block(FIPS_KEY, p, 1'b1, acc_b);
        n_ld += 2;
        wait_ld(n_ld - 1, l_a);
        wait_ld(n_ld, l_b);
        check("b2b_fill_in_run", 128'(acc_b < l_a + CORE_LATENCY), 128'(1));
        check("b2b_ld", 128'(l_b), 128'(l_a + 16));
        drain(1'b0);
        check("b2b_ov", 128'(ov_cyc[ov_cnt-1]), 128'(l_b + CORE_LATENCY + 1));

        // backpressure
        out_ready = 1'b0;
        p = rand128();
        send_block(FIPS_KEY, FIPS_PT, 1'b1, acc_a);
        send_block(FIPS_KEY, p, 1'b1, acc_b);
        n_ld++;
        wait_ld(n_ld, l_a);
        wait_cyc(l_a + CORE_LATENCY + 1);
        check("bp_valid", 128'(out_valid), 128'(1));
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", 128'(out_data), 128'(32'h69c4e0d8));
            tick();
        end
        check("bp_no_launch", 128'(ld_cnt), 128'(n_ld));
        check("bp_in_stall", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        n_ld++;
        drain(1'b0);
        check("bp_second_launch", 128'(ld_cnt), 128'(n_ld));

        // done timeout
        stub_hang = 1'b1;
        send_block(FIPS_KEY, rand128(), 1'b0, acc_a);
        n_ld++;
        wait_ld(n_ld, l_a);
        wait_cyc(l_a + 16);
        check("to_err_pre", 128'(err), 128'(0));
        check("to_busy_pre", 128'(busy), 128'(1));
        tick();
        check("to_err", 128'(err), 128'(1));
        check("to_busy", 128'(busy), 128'(0));
        check("to_no_valid", 128'(out_valid), 128'(0));
        stub_hang = 1'b0;
        send_block(FIPS_KEY, rand128(), 1'b1, acc_a);
        n_ld++;
        drain(1'b0);
        check("to_recover_ld", 128'(ld_cnt), 128'(n_ld));
        check("to_err_sticky", 128'(err), 128'(1));

        // key change coinciding with aes_ld
        send_block(FIPS_KEY, rand128(), 1'b1, acc_a);
        key_in = KEY2;
        key_ld = 1'b1;
        tick();
        key_ld = 1'b0;
        n_ld++;
        wait_ld(n_ld, l_a);
        check("kc_ld_cycle", 128'(l_a), 128'(acc_a + 1));
        send_block(KEY2, rand128(), 1'b1, acc_b);
        n_ld++;
        drain(1'b0);

        // reset while the core is running
        send_block(KEY2, rand128(), 1'b0, acc_a);
        n_ld++;
        wait_ld(n_ld, l_a);
        wait_cyc(l_a + 5);
        rst = 1'b0;
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b1;
        ld_snap = ld_cnt;
        ov_snap = ov_cnt;
        repeat (20) tick();
        check("mid_rst_no_ld", 128'(ld_cnt), 128'(ld_snap));
        check("mid_rst_no_out", 128'(ov_cnt), 128'(ov_snap));

        // random blocks with a jittery consumer
        key_in = KEY2;
        key_ld = 1'b1;
        tick();
        key_ld = 1'b0;
        for (int b = 0; b < 3; b++)
            send_block(KEY2, rand128(), 1'b1, acc_a);
        drain(1'b1);

        check("q_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
